// File: rtl/image_stream_feeder_pkg.sv
// Shared types and helpers for the image stream feeder.
// Holds the FSM state encoding and the index-width function.
package image_stream_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic int calc_bit_size(input int n);
        return $clog2(n * n);
    endfunction

endpackage

// File: rtl/pixel_frame_buffer.sv
// Single-port-write, registered-read frame store.
// A read of the address being written returns the new data.
module pixel_frame_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/image_stream_feeder.sv
// Streams a stored N*N frame to a downstream controller at a fixed pace,
// then drains for TAIL cycles before signalling done.
module image_stream_feeder
    import image_stream_feeder_pkg::*;
#(
    parameter int N          = 8,
    parameter int pixelWidth = 8,
    parameter int PACE       = 2,
    parameter int TAIL       = 576,
    parameter int bitSize    = calc_bit_size(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [bitSize-1:0]    load_addr,
    input  logic [pixelWidth-1:0] load_data,
    input  logic                  start,
    input  logic                  repeat_mode,
    input  logic                  out_ready,
    output logic                  we,
    output logic [pixelWidth-1:0] data_in,
    output logic [bitSize-1:0]    pix_idx,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt
);

    localparam int PIXELS = N * N;
    localparam int PW     = (PACE > 1) ? $clog2(PACE) : 1;
    localparam int DW     = (TAIL > 1) ? $clog2(TAIL) : 1;

    localparam logic [bitSize-1:0] LAST_IDX = bitSize'(PIXELS - 1);
    localparam logic [PW-1:0]      PACE_TOP = PW'(PACE - 1);
    localparam logic [DW-1:0]      TAIL_TOP = DW'(TAIL - 1);

    state_t                  state;
    state_t                  state_next;
    logic [PW-1:0]           pace_cnt;
    logic [DW-1:0]           drain_cnt;
    logic [bitSize-1:0]      pix_idx_next;
    logic                    rpt;
    logic                    issue;
    logic                    consume;
    logic                    last_pix;
    logic                    drain_end;
    logic                    wr_en;
    logic [pixelWidth-1:0]   rd_data;

    assign issue     = (state == STREAM) && (pace_cnt == PACE_TOP);
    assign consume   = issue && out_ready;
    assign last_pix  = (pix_idx == LAST_IDX);
    assign drain_end = (state == DRAIN) && (drain_cnt == TAIL_TOP);
    assign wr_en     = load_en && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (consume && last_pix) state_next = DRAIN;
            DRAIN:   if (drain_end) state_next = rpt ? STREAM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The buffer is addressed with the next index so the pixel is ready
    // in the same cycle its index appears.
    always_comb begin
        pix_idx_next = '0;
        if (state == STREAM) begin
            if (!consume) begin
                pix_idx_next = pix_idx;
            end else if (!last_pix) begin
                pix_idx_next = pix_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx   <= '0;
            pace_cnt  <= '0;
            drain_cnt <= '0;
            rpt       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pix_idx <= pix_idx_next;
            if ((state == IDLE) && start) begin
                rpt <= repeat_mode;
            end
            if ((state != STREAM) || consume) begin
                pace_cnt <= '0;
            end else if (pace_cnt != PACE_TOP) begin
                pace_cnt <= pace_cnt + 1'b1;
            end
            if ((state != DRAIN) || drain_end) begin
                drain_cnt <= '0;
            end else begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (drain_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        we      = issue;
        busy    = (state != IDLE);
        done    = drain_end;
        data_in = issue ? rd_data : '0;
    end

    pixel_frame_buffer #(
        .DEPTH (PIXELS),
        .WIDTH (pixelWidth),
        .AW    (bitSize)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (pix_idx_next),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_image_stream_feeder.sv
// Scoreboard bench: two feeders (PACE=2/TAIL=576 and PACE=1/TAIL=4)
// driven with directed frames, checked by per-instance monitors.
module tb_image_stream_feeder;

    typedef struct {
        int idx;
        int data;
    } pix_t;

    logic       clk = 1'b0;
    logic       a_rst, b_rst;
    logic       a_load_en, b_load_en;
    logic [5:0] load_addr;
    logic [7:0] load_data;
    logic       a_start, b_start, a_rpt, b_rpt, a_ready, b_ready;
    logic       a_we, b_we, a_busy, b_busy, a_done, b_done;
    logic [7:0] a_data, b_data;
    logic [5:0] a_idx, b_idx;
    logic [15:0] a_fcnt, b_fcnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    pix_t qa[$];
    pix_t qb[$];
    pix_t ea, eb;
    int   a_last_cyc = 0, a_last_px = 0, b_last_px = 0;
    logic b_prev_stall = 1'b0;
    int   b_prev_idx = 0, b_prev_data = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    image_stream_feeder #(
        .N(8), .pixelWidth(8), .PACE(2), .TAIL(576)
    ) dut_a (
        .clk(clk), .rst(a_rst), .load_en(a_load_en),
        .load_addr(load_addr), .load_data(load_data),
        .start(a_start), .repeat_mode(a_rpt), .out_ready(a_ready),
        .we(a_we), .data_in(a_data), .pix_idx(a_idx),
        .busy(a_busy), .done(a_done), .frame_cnt(a_fcnt)
    );

    image_stream_feeder #(
        .N(8), .pixelWidth(8), .PACE(1), .TAIL(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .load_en(b_load_en),
        .load_addr(load_addr), .load_data(load_data),
        .start(b_start), .repeat_mode(b_rpt), .out_ready(b_ready),
        .we(b_we), .data_in(b_data), .pix_idx(b_idx),
        .busy(b_busy), .done(b_done), .frame_cnt(b_fcnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit to_a, input int count);
        for (int i = 0; i < count; i++) begin
            if (to_a) qa.push_back('{idx: i, data: i});
            else      qb.push_back('{idx: i, data: i});
        end
    endtask

    task automatic wait_a_done(input int max);
        int n = 0;
        while (!a_done && n < max) begin
            tick();
            n++;
        end
        chk("a_done_seen", a_done, 1);
    endtask

    always @(negedge clk) begin
        if (!a_rst) begin
            if (a_we && a_ready) begin
                if (qa.size() == 0) begin
                    chk("a_extra_pixel", a_idx, -1);
                end else begin
                    ea = qa.pop_front();
                    chk("a_idx", a_idx, ea.idx);
                    chk("a_data", a_data, ea.data);
                    if (a_idx != 0) chk("a_pace", cyc - a_last_cyc, 2);
                end
                a_last_cyc = cyc;
                if (a_idx == 6'd63) a_last_px = cyc;
            end
            if (a_done) chk("a_tail", cyc - a_last_px, 576);
        end
    end

    always @(negedge clk) begin
        if (b_rst) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_prev_stall) begin
                chk("b_hold_we", b_we, 1);
                chk("b_hold_idx", b_idx, b_prev_idx);
                chk("b_hold_data", b_data, b_prev_data);
            end
            if (b_we && b_ready) begin
                if (qb.size() == 0) begin
                    chk("b_extra_pixel", b_idx, -1);
                end else begin
                    eb = qb.pop_front();
                    chk("b_idx", b_idx, eb.idx);
                    chk("b_data", b_data, eb.data);
                end
                if (b_idx == 6'd63) b_last_px = cyc;
            end
            if (b_done) chk("b_tail", cyc - b_last_px, 4);
            b_prev_stall = b_we && !b_ready;
            b_prev_idx   = b_idx;
            b_prev_data  = b_data;
        end
    end

    initial begin
        int n;
        int nd;
        a_rst = 1; b_rst = 1;
        a_load_en = 0; b_load_en = 0;
        load_addr = '0; load_data = '0;
        a_start = 0; b_start = 0; a_rpt = 0; b_rpt = 0;
        a_ready = 1; b_ready = 1;
        tick();
        tick();
        chk("rst_a_we", a_we, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_idx", a_idx, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_fcnt", a_fcnt, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_fcnt", b_fcnt, 0);
        a_rst = 0; b_rst = 0;
        tick();

        // stale value at 0, then 1..63, then 0 written alongside start
        a_load_en = 1; b_load_en = 1;
        load_addr = 6'd0; load_data = 8'hEE;
        tick();
        for (int i = 1; i < 64; i++) begin
            load_addr = 6'(i);
            load_data = 8'(i);
            tick();
        end
        load_addr = 6'd0; load_data = 8'd0;
        a_start = 1; b_start = 1;
        push_frame(1'b1, 64);
        push_frame(1'b0, 64);
        tick();
        a_load_en = 0; b_load_en = 0; a_start = 0; b_start = 0;
        chk("a_busy_run", a_busy, 1);
        for (int k = 0; k < 20; k++) begin
            b_ready = !(k >= 10 && k <= 14);
            tick();
        end
        b_ready = 1;
        wait_a_done(2000);
        tick();
        chk("a_fcnt_1", a_fcnt, 1);
        chk("b_fcnt_1", b_fcnt, 1);
        chk("a_all_seen", qa.size(), 0);
        chk("b_all_seen", qb.size(), 0);
        chk("a_idle", a_busy, 0);
        chk("b_idle", b_busy, 0);

        // repeat mode: three frames, repeat_mode dropped mid-frame
        b_rst = 1;
        tick();
        b_rst = 0;
        b_rpt = 1; b_start = 1;
        push_frame(1'b0, 64);
        push_frame(1'b0, 64);
        push_frame(1'b0, 64);
        tick();
        b_start = 0; b_rpt = 0;
        nd = 0; n = 0;
        while (nd < 3 && n < 1000) begin
            tick();
            n++;
            if (b_done) nd++;
        end
        chk("b_done_count", nd, 3);
        chk("b_fcnt_pre", b_fcnt, 2);
        b_ready = 0;
        tick();
        chk("b_fcnt_3", b_fcnt, 3);
        chk("b_restarted", b_busy, 1);
        chk("b_all_seen_rpt", qb.size(), 0);
        b_rst = 1;
        tick();
        b_rst = 0; b_ready = 1;
        chk("b_rst_we", b_we, 0);
        chk("b_rst_busy", b_busy, 0);

        // reset at pixel 30
        a_rst = 1;
        tick();
        a_rst = 0;
        push_frame(1'b1, 30);
        a_start = 1;
        tick();
        a_start = 0;
        n = 0;
        while (a_idx != 6'd30 && n < 200) begin
            tick();
            n++;
        end
        chk("a_reach_30", a_idx, 30);
        a_rst = 1;
        tick();
        a_rst = 0;
        chk("a_abort_we", a_we, 0);
        chk("a_abort_busy", a_busy, 0);
        chk("a_abort_fcnt", a_fcnt, 0);
        chk("a_abort_seen", qa.size(), 0);
        push_frame(1'b1, 64);
        a_start = 1;
        tick();
        a_start = 0;
        wait_a_done(2000);
        tick();
        chk("a_fcnt_after_abort", a_fcnt, 1);

        // start and load during busy are dropped
        push_frame(1'b1, 64);
        a_start = 1;
        tick();
        a_start = 0;
        repeat (20) tick();
        a_load_en = 1; load_addr = 6'd5; load_data = 8'hAA; a_start = 1;
        tick();
        a_load_en = 0; a_start = 0;
        wait_a_done(2000);
        tick();
        chk("a_idle_after_ignore", a_busy, 0);
        push_frame(1'b1, 64);
        a_start = 1;
        tick();
        a_start = 0;
        wait_a_done(2000);
        tick();
        chk("a_fcnt_3", a_fcnt, 3);
        chk("a_all_seen_end", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_stream_feeder.md
IMAGE_STREAM_FEEDER -- requirements
Module: image_stream_feeder

Interface
REQ-001 Parameter N, default 8: image side in pixels; frame holds N*N pixels.
REQ-002 Parameter pixelWidth, default 8: bits per pixel.
REQ-003 Parameter PACE, default 2: clock cycles per issued pixel; legal range >=1.
REQ-004 Parameter TAIL, default 576: drain cycles after the last pixel before done.
REQ-005 Parameter bitSize, default $clog2(N*N): address/index width; never set manually.
REQ-006 clk  input  1: single clock; all logic on posedge.
REQ-007 rst  input  1: reset, synchronous, active-high.
REQ-008 load_en  input  1: write load_data into frame buffer at load_addr.
REQ-009 load_addr  input  bitSize: frame buffer write address.
REQ-010 load_data  input  pixelWidth: frame buffer write data.
REQ-011 start  input  1: one-cycle request to stream one frame.
REQ-012 repeat_mode  input  1: sampled at start; 1 = restart the frame automatically after each drain.
REQ-013 out_ready  input  1: downstream can accept a pixel this cycle.
REQ-014 we  output  1: pixel-valid/write-enable to the downstream controller.
REQ-015 data_in  output  pixelWidth: pixel driven to downstream; stable while we is high.
REQ-016 pix_idx  output  bitSize: raster index of the current data_in.
REQ-017 busy  output  1: high in any state other than IDLE.
REQ-018 done  output  1: one-cycle pulse when a frame's drain completes.
REQ-019 frame_cnt  output  16: frames completed since reset; wraps at 2^16.

Function
REQ-020 FSM states: IDLE, STREAM, DRAIN, with the transitions given in REQ-021..REQ-026.
REQ-021 IDLE -> STREAM on start; pix_idx=0; pace counter=0; repeat_mode latched.
REQ-022 In STREAM, we=1 exactly when the pace counter = PACE-1; data_in=buffer[pix_idx], registered, with 1-cycle read latency hidden by prefetch.
REQ-023 A pixel is consumed on a cycle with we && out_ready; otherwise we, data_in and pix_idx hold and the pace counter freezes.
REQ-024 After consumption, pix_idx increments and the pace counter resets to 0; with PACE=1, pixels issue back-to-back.
REQ-025 Consumption of pix_idx=N*N-1 -> DRAIN; we=0; drain counter=0.
REQ-026 DRAIN lasts exactly TAIL cycles, then: done pulses for 1 cycle, frame_cnt+1, next state STREAM if the latched repeat is 1 else IDLE.
REQ-027 start is ignored while busy=1.
REQ-028 load_en writes only while busy=0; load_en during busy is dropped without error.
REQ-029 load_en and start in the same IDLE cycle: the write completes first, and the stream sees the new data.
REQ-030 Deasserting repeat_mode mid-frame has no effect until the next start.

Reset
REQ-031 rst=1 at any clk edge -> IDLE; we=0, data_in=0, pix_idx=0, busy=0, done=0, frame_cnt=0, all counters 0.
REQ-032 Frame buffer contents are not cleared by rst.
REQ-033 rst mid-frame or mid-drain aborts with no done pulse and no frame_cnt increment.

Structure
REQ-034 A shared package holds the FSM state enum and a function computing bitSize from N.
REQ-035 Sub-module pixel_frame_buffer: N*N x pixelWidth, single write port and single registered read port; the rest is FSM and counters.

Verification
REQ-036 Load 64 pixels with value = address, PACE=2, out_ready=1, start -> 64 we pulses on every second cycle, data 0..63, then done exactly 576 cycles after the last pulse, frame_cnt=1.
REQ-037 PACE=1, out_ready low for cycles 10-14 of the stream -> data_in/pix_idx held over that window, no pixel skipped or duplicated, all 64 delivered.
REQ-038 repeat_mode=1, TAIL=4 -> three consecutive frames with identical data; done pulses 3 times; frame_cnt=3.
REQ-039 rst asserted at pixel 30 -> next cycle we=0, busy=0, frame_cnt unchanged; a new start streams from pix_idx 0 with buffer contents intact.
REQ-040 start and load_en to address 5 with value 0xAA while busy -> both ignored; output matches the original frame; a second start after done streams normally.
